rd_tag_tracker: RTL and testbench
=================================

RD_TAG_TRACKER -- requirements
Module: rd_tag_tracker

Interface
REQ-001 Parameter TAG_BITS, default 6; tag width, giving 2^TAG_BITS tag slots.
REQ-002 Parameter ADDR_BITS, default 42; cache-line address width.
REQ-003 Parameter ID_BITS, default 16; client request ID width.
REQ-004 Parameter DATA_BITS, default 512; cache-line data width.
REQ-005 clk  in  1  clock; all logic is rising-edge.
REQ-006 reset  in  1  reset, synchronous, active-high.
REQ-007 in_valid  in  1  client read request valid.
REQ-008 in_ready  out  1  tracker accepts the request this cycle.
REQ-009 in_addr  in  ADDR_BITS  client line address.
REQ-010 in_id  in  ID_BITS  client request ID.
REQ-011 fiu_alm_full  in  1  host read channel almost full.
REQ-012 out_rd_en  out  1  read request issued to host.
REQ-013 out_rd_addr  out  ADDR_BITS  issued line address.
REQ-014 out_rd_mdata  out  16  issued metadata: tag zero-extended.
REQ-015 rsp_valid  in  1  host read response valid.
REQ-016 rsp_mdata  in  16  response metadata.
REQ-017 rsp_data  in  DATA_BITS  response line.
REQ-018 cl_rsp_valid / cl_rsp_id / cl_rsp_data  out  1 / ID_BITS / DATA_BITS  response returned to the client.
REQ-019 outstanding  out  TAG_BITS+1  count of tags in flight.
REQ-020 idle  out  1  RUN state and outstanding==0.
REQ-021 tag_err  out  1  sticky flag: response carried a tag that was not in flight.

Function
REQ-022 States INIT and RUN; reset enters INIT.
- INIT: load tags 0..2^TAG_BITS-1 into the free FIFO, one per cycle; in_ready=0.
- Go to RUN the cycle after the last tag is loaded, 2^TAG_BITS cycles after reset deasserts.
REQ-023 in_ready = RUN & free FIFO not empty & !fiu_alm_full.
- Accept = in_valid & in_ready.
REQ-024 On accept, pop the head tag T and store in_id in id_table[T].
- Set inflight[T].
- Next cycle: out_rd_en=1, out_rd_addr=in_addr (registered), out_rd_mdata=T (1-cycle latency).
REQ-025 On rsp_valid with rsp_mdata[TAG_BITS-1:0]=T and inflight[T]=1:
- Next cycle: cl_rsp_valid=1, cl_rsp_id=id_table[T], cl_rsp_data=rsp_data.
- Clear inflight[T] and push T to the free FIFO.
REQ-026 On rsp_valid with inflight[T]=0:
- Set tag_err; no client response; no push.
- tag_err clears only on reset.
REQ-027 rsp_mdata bits above TAG_BITS are ignored.
REQ-028 Accept and response in the same cycle are both serviced:
- outstanding is unchanged.
- An empty free FIFO does not accept; the freed tag is usable next cycle.
REQ-029 outstanding increments on accept and decrements on a valid response; it never exceeds 2^TAG_BITS.
REQ-030 Responses can arrive in any order; the client sees them in host arrival order.
REQ-031 rsp_valid during INIT is treated as a tag error.

Reset
REQ-032 Reset values:
- Outputs: out_rd_en=0, cl_rsp_valid=0, in_ready=0, outstanding=0, idle=0, tag_err=0.
- Internal: inflight all 0, free FIFO empty, state INIT.
REQ-033 Reset mid-operation discards all in-flight tags; late responses after reset raise tag_err.

Configuration
REQ-034 Macro RD_TAG_TRACKER_STATS_EN.
- Defined: add outputs stat_reqs (64-bit count of accepts) and stat_max_out (TAG_BITS+1, peak outstanding); both reset to 0.
- Undefined: neither port nor its logic exists.

Structure
REQ-035 Package rd_tag_pkg holds the t_tag and t_req_id typedefs and the NUM_TAGS constant.
REQ-036 Sub-module tag_free_fifo is a 2^TAG_BITS-deep, TAG_BITS-wide, synchronous FIFO with simultaneous push and pop.

Verification
REQ-037 Reset, then hold idle: in_ready rises at cycle 64; idle=1; outstanding=0.
REQ-038 Accept addr 0x100, id 0xA5: next cycle out_rd_en=1, mdata=0. Return rsp mdata 0: cl_rsp_id=0xA5 one cycle later.
REQ-039 Issue 64 requests with no responses: in_ready=0, outstanding=64. One response frees its tag: the next accept reuses that tag.
REQ-040 Accept and response in the same cycle at outstanding=10: outstanding stays 10.
REQ-041 Response with mdata 5 when tag 5 is not in flight: tag_err=1, cl_rsp_valid=0, outstanding unchanged.
REQ-042 fiu_alm_full=1 with in_valid=1: in_ready=0 and no out_rd_en until fiu_alm_full drops.

Source files
------------

// File: rtl/rd_tag_pkg.sv
// rtl/rd_tag_pkg.sv - shared types and constants for the read tag tracker
package rd_tag_pkg;

    // Default build widths; the tracker parameters default to these values.
    localparam int TAG_BITS_DEF = 6;
    localparam int ID_BITS_DEF  = 16;
    localparam int NUM_TAGS     = 1 << TAG_BITS_DEF;

    typedef logic [TAG_BITS_DEF-1:0] t_tag;
    typedef logic [ID_BITS_DEF-1:0]  t_req_id;

    // INIT seeds the free list after reset, RUN is normal operation.
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } t_state;

endpackage

// File: rtl/tag_free_fifo.sv
// rtl/tag_free_fifo.sv - free tag list, 2^TAG_BITS deep, simultaneous push and pop
module tag_free_fifo #(
    parameter int TAG_BITS = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                push,
    input  logic [TAG_BITS-1:0] push_tag,
    input  logic                pop,
    output logic [TAG_BITS-1:0] pop_tag,
    output logic                empty
);

    localparam int DEPTH = 1 << TAG_BITS;
    localparam logic [TAG_BITS:0] DEPTH_CNT = (TAG_BITS+1)'(DEPTH);

    logic [TAG_BITS-1:0] mem_q [DEPTH];
    logic [TAG_BITS-1:0] mem_d [DEPTH];
    logic [TAG_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [TAG_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [TAG_BITS:0]   count_q, count_d;
    logic                full;
    logic                do_push;
    logic                do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == DEPTH_CNT);
    assign pop_tag = mem_q[rd_ptr_q];

    // Pointer, occupancy and storage update; a push into a full list is only
    // taken when a pop frees a slot in the same cycle.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = push_tag;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Tag storage; contents are meaningless while the list is empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/rd_tag_tracker.sv
// rtl/rd_tag_tracker.sv - host read tag allocation and response routing (optional RD_TAG_TRACKER_STATS_EN)
module rd_tag_tracker
    import rd_tag_pkg::*;
#(
    parameter int TAG_BITS  = TAG_BITS_DEF,
    parameter int ADDR_BITS = 42,
    parameter int ID_BITS   = ID_BITS_DEF,
    parameter int DATA_BITS = 512
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ADDR_BITS-1:0] in_addr,
    input  logic [ID_BITS-1:0]   in_id,
    input  logic                 fiu_alm_full,
    output logic                 out_rd_en,
    output logic [ADDR_BITS-1:0] out_rd_addr,
    output logic [15:0]          out_rd_mdata,
    input  logic                 rsp_valid,
    input  logic [15:0]          rsp_mdata,
    input  logic [DATA_BITS-1:0] rsp_data,
    output logic                 cl_rsp_valid,
    output logic [ID_BITS-1:0]   cl_rsp_id,
    output logic [DATA_BITS-1:0] cl_rsp_data,
    output logic [TAG_BITS:0]    outstanding,
    output logic                 idle,
    output logic                 tag_err
`ifdef RD_TAG_TRACKER_STATS_EN
    ,
    output logic [63:0]          stat_reqs,
    output logic [TAG_BITS:0]    stat_max_out
`endif
);

    localparam int N_TAGS = 1 << TAG_BITS;

    t_state               state_q, state_d;
    logic [TAG_BITS-1:0]  init_cnt_q, init_cnt_d;
    logic [N_TAGS-1:0]    inflight_q, inflight_d;
    logic [ID_BITS-1:0]   id_table_q [N_TAGS];
    logic [ID_BITS-1:0]   id_table_d [N_TAGS];
    logic [TAG_BITS:0]    outstanding_q, outstanding_d;
    logic                 tag_err_q, tag_err_d;
    logic                 out_rd_en_q, out_rd_en_d;
    logic [ADDR_BITS-1:0] out_rd_addr_q, out_rd_addr_d;
    logic [15:0]          out_rd_mdata_q, out_rd_mdata_d;
    logic                 cl_rsp_valid_q, cl_rsp_valid_d;
    logic [ID_BITS-1:0]   cl_rsp_id_q, cl_rsp_id_d;
    logic [DATA_BITS-1:0] cl_rsp_data_q, cl_rsp_data_d;

    logic                 fifo_push;
    logic [TAG_BITS-1:0]  fifo_push_tag;
    logic                 fifo_pop;
    logic [TAG_BITS-1:0]  fifo_head;
    logic                 fifo_empty;

    logic [TAG_BITS-1:0]  rsp_tag;
    logic                 rsp_hit;
    logic                 accept;
    logic                 unused_mdata_hi;

    // Only the low tag bits of the returned metadata identify the request.
    assign rsp_tag         = rsp_mdata[TAG_BITS-1:0];
    assign unused_mdata_hi = ^rsp_mdata[15:TAG_BITS];

    // A response during INIT never matches: inflight is clear until RUN.
    assign rsp_hit  = rsp_valid & (state_q == ST_RUN) & inflight_q[rsp_tag];
    assign in_ready = (state_q == ST_RUN) & ~fifo_empty & ~fiu_alm_full;
    assign accept   = in_valid & in_ready;
    assign fifo_pop = accept;

    tag_free_fifo #(
        .TAG_BITS (TAG_BITS)
    ) u_free_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifo_push),
        .push_tag (fifo_push_tag),
        .pop      (fifo_pop),
        .pop_tag  (fifo_head),
        .empty    (fifo_empty)
    );

    // Next state: INIT seeds one tag per cycle, RUN follows the last seed.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        if (state_q == ST_INIT) begin
            init_cnt_d = init_cnt_q + 1'b1;
            if (init_cnt_q == '1) begin
                state_d = ST_RUN;
            end
        end
    end

    // Tag bookkeeping, request issue and response return.
    always_comb begin
        inflight_d     = inflight_q;
        id_table_d     = id_table_q;
        outstanding_d  = outstanding_q;
        tag_err_d      = tag_err_q;
        out_rd_en_d    = accept;
        out_rd_addr_d  = out_rd_addr_q;
        out_rd_mdata_d = out_rd_mdata_q;
        cl_rsp_valid_d = rsp_hit;
        cl_rsp_id_d    = cl_rsp_id_q;
        cl_rsp_data_d  = cl_rsp_data_q;
        fifo_push      = 1'b0;
        fifo_push_tag  = init_cnt_q;

        if (state_q == ST_INIT) begin
            fifo_push = 1'b1;
        end else if (rsp_hit) begin
            fifo_push     = 1'b1;
            fifo_push_tag = rsp_tag;
        end

        if (accept) begin
            inflight_d[fifo_head] = 1'b1;
            id_table_d[fifo_head] = in_id;
            out_rd_addr_d         = in_addr;
            out_rd_mdata_d        = 16'(fifo_head);
        end

        // The accepted tag came from the free list, so it never equals the
        // in-flight tag being retired in the same cycle.
        if (rsp_hit) begin
            inflight_d[rsp_tag] = 1'b0;
            cl_rsp_id_d         = id_table_q[rsp_tag];
            cl_rsp_data_d       = rsp_data;
        end else if (rsp_valid) begin
            tag_err_d = 1'b1;
        end

        case ({accept, rsp_hit})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    // FSM and control registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_INIT;
            init_cnt_q     <= '0;
            inflight_q     <= '0;
            outstanding_q  <= '0;
            tag_err_q      <= 1'b0;
            out_rd_en_q    <= 1'b0;
            out_rd_addr_q  <= '0;
            out_rd_mdata_q <= '0;
            cl_rsp_valid_q <= 1'b0;
            cl_rsp_id_q    <= '0;
            cl_rsp_data_q  <= '0;
        end else begin
            state_q        <= state_d;
            init_cnt_q     <= init_cnt_d;
            inflight_q     <= inflight_d;
            outstanding_q  <= outstanding_d;
            tag_err_q      <= tag_err_d;
            out_rd_en_q    <= out_rd_en_d;
            out_rd_addr_q  <= out_rd_addr_d;
            out_rd_mdata_q <= out_rd_mdata_d;
            cl_rsp_valid_q <= cl_rsp_valid_d;
            cl_rsp_id_q    <= cl_rsp_id_d;
            cl_rsp_data_q  <= cl_rsp_data_d;
        end
    end

    // Client ID per tag; an entry is only read while its tag is in flight.
    always_ff @(posedge clk) begin
        id_table_q <= id_table_d;
    end

    assign out_rd_en    = out_rd_en_q;
    assign out_rd_addr  = out_rd_addr_q;
    assign out_rd_mdata = out_rd_mdata_q;
    assign cl_rsp_valid = cl_rsp_valid_q;
    assign cl_rsp_id    = cl_rsp_id_q;
    assign cl_rsp_data  = cl_rsp_data_q;
    assign outstanding  = outstanding_q;
    assign idle         = (state_q == ST_RUN) & (outstanding_q == '0);
    assign tag_err      = tag_err_q;

`ifdef RD_TAG_TRACKER_STATS_EN
    logic [63:0]       stat_reqs_q, stat_reqs_d;
    logic [TAG_BITS:0] stat_max_out_q, stat_max_out_d;

    // Accept count and high-water mark of tags in flight.
    always_comb begin
        stat_reqs_d    = stat_reqs_q + 64'(accept);
        stat_max_out_d = stat_max_out_q;
        if (outstanding_d > stat_max_out_q) begin
            stat_max_out_d = outstanding_d;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_reqs_q    <= '0;
            stat_max_out_q <= '0;
        end else begin
            stat_reqs_q    <= stat_reqs_d;
            stat_max_out_q <= stat_max_out_d;
        end
    end

    assign stat_reqs    = stat_reqs_q;
    assign stat_max_out = stat_max_out_q;
`endif

endmodule

// File: tb/tb_rd_tag_tracker.sv
// tb/tb_rd_tag_tracker.sv - directed vector bench for rd_tag_tracker
module tb_rd_tag_tracker;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [41:0]  in_addr;
    logic [15:0]  in_id;
    logic         fiu_alm_full;
    logic         out_rd_en;
    logic [41:0]  out_rd_addr;
    logic [15:0]  out_rd_mdata;
    logic         rsp_valid;
    logic [15:0]  rsp_mdata;
    logic [511:0] rsp_data;
    logic         cl_rsp_valid;
    logic [15:0]  cl_rsp_id;
    logic [511:0] cl_rsp_data;
    logic [6:0]   outstanding;
    logic         idle;
    logic         tag_err;
`ifdef RD_TAG_TRACKER_STATS_EN
    logic [63:0]  stat_reqs;
    logic [6:0]   stat_max_out;
`endif

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    rd_tag_tracker dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_addr      (in_addr),
        .in_id        (in_id),
        .fiu_alm_full (fiu_alm_full),
        .out_rd_en    (out_rd_en),
        .out_rd_addr  (out_rd_addr),
        .out_rd_mdata (out_rd_mdata),
        .rsp_valid    (rsp_valid),
        .rsp_mdata    (rsp_mdata),
        .rsp_data     (rsp_data),
        .cl_rsp_valid (cl_rsp_valid),
        .cl_rsp_id    (cl_rsp_id),
        .cl_rsp_data  (cl_rsp_data),
        .outstanding  (outstanding),
        .idle         (idle),
        .tag_err      (tag_err)
`ifdef RD_TAG_TRACKER_STATS_EN
        ,
        .stat_reqs    (stat_reqs),
        .stat_max_out (stat_max_out)
`endif
    );

    typedef struct {
        logic        vin;
        logic [41:0] addr;
        logic [15:0] id;
        logic        fiu;
        logic        rv;
        logic [15:0] rm;
        logic [31:0] rd;
        logic        e_rdy;
        logic        e_rd_en;
        logic [15:0] e_md;
        logic [41:0] e_addr;
        logic        e_cl;
        logic [15:0] e_id;
        logic [31:0] e_data;
        logic [6:0]  e_out;
        logic        e_err;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        in_valid     = 1'b0;
        in_addr      = '0;
        in_id        = '0;
        fiu_alm_full = 1'b0;
        rsp_valid    = 1'b0;
        rsp_mdata    = '0;
        rsp_data     = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_init(output int n);
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;

        //            vin addr    id     fiu rv rm       rd          rdy en md addr    cl id     data        out err
        vecs[0]  = '{1, 42'h100, 16'hA5, 0, 0, 16'h0,    32'h0,      1, 0, 0, 42'h0,   0, 16'h0,  32'h0,      0, 0};
        vecs[1]  = '{0, 42'h0,   16'h0,  0, 0, 16'h0,    32'h0,      1, 1, 0, 42'h100, 0, 16'h0,  32'h0,      1, 0};
        vecs[2]  = '{0, 42'h0,   16'h0,  0, 1, 16'h0,    32'hDEAD,   1, 0, 0, 42'h0,   0, 16'h0,  32'h0,      1, 0};
        vecs[3]  = '{0, 42'h0,   16'h0,  0, 0, 16'h0,    32'h0,      1, 0, 0, 42'h0,   1, 16'hA5, 32'hDEAD,   0, 0};
        vecs[4]  = '{1, 42'h200, 16'h11, 0, 0, 16'h0,    32'h0,      1, 0, 0, 42'h0,   0, 16'h0,  32'h0,      0, 0};
        vecs[5]  = '{1, 42'h240, 16'h22, 0, 0, 16'h0,    32'h0,      1, 1, 1, 42'h200, 0, 16'h0,  32'h0,      1, 0};
        vecs[6]  = '{1, 42'h280, 16'h99, 1, 1, 16'h2,    32'h2222,   0, 1, 2, 42'h240, 0, 16'h0,  32'h0,      2, 0};
        vecs[7]  = '{1, 42'h280, 16'h99, 1, 1, 16'h0101, 32'h1111,   0, 0, 0, 42'h0,   1, 16'h22, 32'h2222,   1, 0};
        vecs[8]  = '{1, 42'h300, 16'h33, 0, 0, 16'h0,    32'h0,      1, 0, 0, 42'h0,   1, 16'h11, 32'h1111,   0, 0};
        vecs[9]  = '{0, 42'h0,   16'h0,  0, 1, 16'h5,    32'h5555,   1, 1, 3, 42'h300, 0, 16'h0,  32'h0,      1, 0};
        vecs[10] = '{0, 42'h0,   16'h0,  0, 0, 16'h0,    32'h0,      1, 0, 0, 42'h0,   0, 16'h0,  32'h0,      1, 1};
        vecs[11] = '{0, 42'h0,   16'h0,  0, 0, 16'h0,    32'h0,      1, 0, 0, 42'h0,   0, 16'h0,  32'h0,      1, 1};

        // Reset values, then the INIT window length.
        reset = 1'b1;
        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_rd_en", out_rd_en, 0);
        chk("rst_cl_rsp_valid", cl_rsp_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_idle", idle, 0);
        chk("rst_tag_err", tag_err, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        wait_init(n);
        chk("init_cycles", n, 64);
        chk("init_idle", idle, 1);
        chk("init_outstanding", outstanding, 0);

        // Directed vector table.
        for (int i = 0; i < 12; i++) begin
            in_valid     = vecs[i].vin;
            in_addr      = vecs[i].addr;
            in_id        = vecs[i].id;
            fiu_alm_full = vecs[i].fiu;
            rsp_valid    = vecs[i].rv;
            rsp_mdata    = vecs[i].rm;
            rsp_data     = {480'b0, vecs[i].rd};
            @(negedge clk);
            chk($sformatf("v%0d_in_ready", i), in_ready, vecs[i].e_rdy);
            chk($sformatf("v%0d_out_rd_en", i), out_rd_en, vecs[i].e_rd_en);
            if (vecs[i].e_rd_en) begin
                chk($sformatf("v%0d_mdata", i), out_rd_mdata, vecs[i].e_md);
                chk($sformatf("v%0d_rd_addr", i), out_rd_addr, vecs[i].e_addr);
            end
            chk($sformatf("v%0d_cl_valid", i), cl_rsp_valid, vecs[i].e_cl);
            if (vecs[i].e_cl) begin
                chk($sformatf("v%0d_cl_id", i), cl_rsp_id, vecs[i].e_id);
                chk($sformatf("v%0d_cl_data", i), cl_rsp_data, {480'b0, vecs[i].e_data});
            end
            chk($sformatf("v%0d_outstanding", i), outstanding, vecs[i].e_out);
            chk($sformatf("v%0d_idle", i), idle, (vecs[i].e_out == 0));
            chk($sformatf("v%0d_tag_err", i), tag_err, vecs[i].e_err);
            @(posedge clk);
            #1;
        end

        // Exhaust all 64 tags, then free one and reuse it.
        do_reset();
        wait_init(n);
        chk("fill_init_bound", (n < 200), 1);
        for (int i = 0; i < 64; i++) begin
            in_valid = 1'b1;
            in_id    = 16'(i);
            in_addr  = 42'(i);
            @(negedge clk);
            chk($sformatf("fill%0d_rdy", i), in_ready, 1);
            if (i > 0) chk($sformatf("fill%0d_tag", i), out_rd_mdata, 16'(i - 1));
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b1;
        in_id     = 16'h77;
        rsp_valid = 1'b1;
        rsp_mdata = 16'd17;
        @(negedge clk);
        chk("full_last_tag", out_rd_mdata, 63);
        chk("full_in_ready", in_ready, 0);
        chk("full_outstanding", outstanding, 64);
        @(posedge clk);
        #1;
        rsp_valid = 1'b0;
        @(negedge clk);
        chk("free_cl_valid", cl_rsp_valid, 1);
        chk("free_cl_id", cl_rsp_id, 17);
        chk("free_outstanding", outstanding, 63);
        chk("free_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("reuse_rd_en", out_rd_en, 1);
        chk("reuse_tag", out_rd_mdata, 17);
        chk("reuse_outstanding", outstanding, 64);

        // Response during INIT, then accept and response together at 10 out.
        @(posedge clk);
        #1;
        do_reset();
        rsp_valid = 1'b1;
        rsp_mdata = 16'd0;
        @(posedge clk);
        #1;
        rsp_valid = 1'b0;
        @(negedge clk);
        chk("init_rsp_tag_err", tag_err, 1);
        chk("init_rsp_cl_valid", cl_rsp_valid, 0);
        wait_init(n);
        chk("same_init_bound", (n < 200), 1);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_id    = 16'h40 + 16'(i);
            in_addr  = 42'h400 + 42'(i);
            @(posedge clk);
            #1;
        end
        in_id     = 16'h77;
        in_addr   = 42'h500;
        rsp_valid = 1'b1;
        rsp_mdata = 16'd3;
        @(negedge clk);
        chk("same_pre_outstanding", outstanding, 10);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        rsp_valid = 1'b0;
        @(negedge clk);
        chk("same_outstanding", outstanding, 10);
        chk("same_cl_valid", cl_rsp_valid, 1);
        chk("same_cl_id", cl_rsp_id, 16'h43);
        chk("same_rd_en", out_rd_en, 1);
        chk("same_tag", out_rd_mdata, 10);
        chk("same_addr", out_rd_addr, 42'h500);

        // Reset mid-operation: a late response is a tag error.
        @(posedge clk);
        #1;
        do_reset();
        wait_init(n);
        chk("late_init_bound", (n < 200), 1);
        chk("late_outstanding", outstanding, 0);
        rsp_valid = 1'b1;
        rsp_mdata = 16'd2;
        @(posedge clk);
        #1;
        rsp_valid = 1'b0;
        @(negedge clk);
        chk("late_tag_err", tag_err, 1);
        chk("late_cl_valid", cl_rsp_valid, 0);
        chk("late_outstanding_after", outstanding, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
